ex_muldiv: RTL and testbench
============================

// Module: ex_muldiv
// PURPOSE
//  RV32M multiply/divide unit in EX; consumes the ID/EX pipeline register outputs.
//  Iterative engine: one 32-cycle shift-add (mul) or restoring-subtract (div) pass.
//  While busy, it drives stall_req_o so the pipeline control drops lden on the ID/EX register.
//  Result goes to the EX write-back mux with its own valid, rd and wen.
// PARAMETERS
//  DATA_W  32  operand/result width; must equal the `RegBus width
//  CNT_W   6   iteration counter width; covers 0..DATA_W
// PORTS
//  clk             in   1       core clock
//  rstn            in   1       async active-low reset
//  inst_i          in   32      instruction from ID/EX
//  instaddr_i      in   32      instruction address; unused internally, kept for trace
//  op1_i           in   32      rs1 value
//  op2_i           in   32      rs2 value
//  regs_wen_i      in   1       rd write enable from decode
//  rd_addr_i       in   5       destination register
//  flush_i         in   1       pipeline flush; aborts the current operation
//  stall_req_o     out  1       hold ID/EX and earlier stages
//  busy_o          out  1       FSM not in IDLE
//  result_valid_o  out  1       one-cycle pulse; result_o is valid
//  result_o        out  32      mul/div result
//  regs_wen_o      out  1       latched regs_wen_i; qualified by result_valid_o
//  rd_addr_o       out  5       latched rd_addr_i
// BEHAVIOUR
//  Reset: state=IDLE; all outputs 0.
//  start = IDLE & opcode==0110011 & funct7==0000001 & !flush_i.
//    funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
//  stall_req_o = (IDLE & start) | CALC. Combinational, so ID/EX holds in the accept cycle.
//  FSM:
//    IDLE->CALC on start (normal case).
//    IDLE->DONE on start with a fast-path case (below).
//    CALC->DONE when cnt==DATA_W-1.
//    DONE->IDLE unconditionally.
//  Any state -> IDLE on flush_i; result_valid_o is never raised for the aborted op.
//  Accept edge:
//    latch |op1|, |op2|, funct3, rd_addr_i, regs_wen_i.
//    latch result-sign flags: signed ops only; MULHSU uses op1 sign only.
//    cnt=0.
//  CALC: one iteration per cycle, DATA_W cycles.
//    mul: 64-bit accumulator, shift-add.
//    div: restoring; quotient and remainder registers.
//  DONE: result_valid_o=1 for exactly one cycle; stall_req_o=0.
//    Result selection:
//      MUL:  low 32 bits of the product.
//      MULH*: high 32 bits of the product.
//      DIV*: quotient.
//      REM*: remainder.
//    Sign fix: negate the product if the operand signs differ. Quotient is negative when the
//    operand signs differ; remainder takes the dividend's sign.
//  DONE never re-accepts. ID/EX still shows the same instruction in DONE and loads the next
//    one at the DONE edge.
//  Latency: normal = accept cycle + 32 CALC + DONE. result_valid_o 33 cycles after accept;
//    stall_req_o high 33 cycles.
//  Fast path (IDLE->DONE, stall 1 cycle, result_valid_o 1 cycle after accept):
//    div by zero: quotient=0xFFFFFFFF; remainder=op1.
//    DIV/REM of 0x80000000 by 0xFFFFFFFF: quotient=0x80000000; remainder=0.
//  Non-M instruction: no stall and no valid; the module stays in IDLE.
//  Async reset mid-operation: immediately IDLE; stall_req_o=0.
//  flush_i and start in the same cycle: flush wins, no accept.
// STRUCTURE
//  defines.v gets:
//    `INST_TYPE_R_M, `FUNCT7_M, the eight funct3 codes.
//    MD state encodings: IDLE=2'b00, CALC=2'b01, DONE=2'b10.
//  Sub-module md_iter_core: accumulator, quotient/remainder registers, cnt, one step per cycle.
//  ex_muldiv keeps the FSM, operand conditioning, fast-path detect and sign fix.
//  All state flops use gnrl_dfflr.
// TESTING
//  MUL 7 * 0xFFFFFFFD
//    -> result_o=0xFFFFFFEB, result_valid_o 33 cycles after accept, stall_req_o high 33 cycles.
//  MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE.
//  MULHSU 0xFFFFFFFF*2 -> 0xFFFFFFFF.
//  MULH 0x80000000*0x80000000 -> 0x40000000.
//  DIVU 100/0 -> 0xFFFFFFFF.
//  REMU 100/0 -> 100.
//    Both divide-by-zero cases: valid 1 cycle after accept, stall high 1 cycle only.
//  DIV 0x80000000/0xFFFFFFFF -> 0x80000000.
//  REM of the same operands -> 0.
//  DIV -7/2 -> 0xFFFFFFFD.
//  REM -7/2 -> 0xFFFFFFFF.
//  flush_i in CALC cycle 10 -> no valid pulse, stall_req_o low next cycle, IDLE.
//    A following DIVU 9/3 -> 3.
//  Back-to-back MUL,MUL: second accepted the cycle after DONE; two valid pulses 34 cycles apart.
//    An ADD in between -> no stall.

Source files
------------

// File: rtl/ex_muldiv_pkg.sv
// Shared constants, opcode fields and FSM encoding for the RV32M multiply/divide unit.
package ex_muldiv_pkg;

    localparam int unsigned MD_DATA_W = 32;
    localparam int unsigned MD_CNT_W  = 6;

    localparam logic [6:0] INST_TYPE_R_M = 7'b0110011;
    localparam logic [6:0] FUNCT7_M      = 7'b0000001;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    typedef enum logic [1:0] {
        MD_IDLE = 2'b00,
        MD_CALC = 2'b01,
        MD_DONE = 2'b10
    } md_state_e;

endpackage

// File: rtl/ex_muldiv_md_iter_core.sv
// Iterative datapath: one shift-add (mul) or restoring-subtract (div) step per cycle.
// A single 2*DATA_W accumulator serves both: mul keeps {partial_hi, multiplier},
// div keeps {remainder, dividend/quotient}.
module ex_muldiv_md_iter_core
    import ex_muldiv_pkg::*;
#(
    parameter int unsigned DATA_W = MD_DATA_W,
    parameter int unsigned CNT_W  = MD_CNT_W
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                load_i,
    input  logic                is_div_i,
    input  logic [DATA_W-1:0]   a_i,
    input  logic [DATA_W-1:0]   b_i,
    input  logic                step_i,
    output logic [2*DATA_W-1:0] acc_o,
    output logic                cnt_last_c
);

    logic [2*DATA_W-1:0] acc_q, acc_d;
    logic [DATA_W-1:0]   opnd_q, opnd_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                div_q, div_d;

    logic [DATA_W:0]     mul_sum;
    logic [DATA_W:0]     div_sh;
    logic                div_ge;
    logic [DATA_W-1:0]   div_rem;

    // Load operands on accept, otherwise advance one iteration while stepping
    always_comb begin
        acc_d  = acc_q;
        opnd_d = opnd_q;
        cnt_d  = cnt_q;
        div_d  = div_q;

        mul_sum = {1'b0, acc_q[2*DATA_W-1:DATA_W]} + (acc_q[0] ? {1'b0, opnd_q} : {(DATA_W+1){1'b0}});
        div_sh  = acc_q[2*DATA_W-1:DATA_W-1];
        div_ge  = (div_sh >= {1'b0, opnd_q});
        div_rem = div_ge ? DATA_W'(div_sh - {1'b0, opnd_q}) : div_sh[DATA_W-1:0];

        if (load_i) begin
            div_d  = is_div_i;
            opnd_d = is_div_i ? b_i : a_i;
            acc_d  = {{DATA_W{1'b0}}, (is_div_i ? a_i : b_i)};
            cnt_d  = '0;
        end else if (step_i) begin
            if (div_q) begin
                acc_d = {div_rem, acc_q[DATA_W-2:0], div_ge};
            end else begin
                acc_d = {mul_sum, acc_q[DATA_W-1:1]};
            end
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Datapath registers
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            acc_q  <= '0;
            opnd_q <= '0;
            cnt_q  <= '0;
            div_q  <= 1'b0;
        end else begin
            acc_q  <= acc_d;
            opnd_q <= opnd_d;
            cnt_q  <= cnt_d;
            div_q  <= div_d;
        end
    end

    assign acc_o      = acc_q;
    assign cnt_last_c = (cnt_q == CNT_W'(DATA_W - 1));

endmodule

// File: rtl/ex_muldiv.sv
// RV32M multiply/divide unit in EX: FSM, operand conditioning, fast paths and sign fix.
module ex_muldiv
    import ex_muldiv_pkg::*;
#(
    parameter int unsigned DATA_W = MD_DATA_W,
    parameter int unsigned CNT_W  = MD_CNT_W
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [31:0]       inst_i,
    input  logic [31:0]       instaddr_i,
    input  logic [DATA_W-1:0] op1_i,
    input  logic [DATA_W-1:0] op2_i,
    input  logic              regs_wen_i,
    input  logic [4:0]        rd_addr_i,
    input  logic              flush_i,
    output logic              stall_req_o,
    output logic              busy_o,
    output logic              result_valid_o,
    output logic [DATA_W-1:0] result_o,
    output logic              regs_wen_o,
    output logic [4:0]        rd_addr_o
);

    localparam logic [DATA_W-1:0] SMIN = {1'b1, {(DATA_W-1){1'b0}}};

    md_state_e           state_q, state_d;
    logic [2:0]          funct3_q, funct3_d;
    logic                neg_prod_q, neg_prod_d;
    logic                neg_rem_q, neg_rem_d;
    logic                fast_q, fast_d;
    logic [DATA_W-1:0]   fast_res_q, fast_res_d;
    logic                regs_wen_q, regs_wen_d;
    logic [4:0]          rd_addr_q, rd_addr_d;

    logic [2:0]          funct3_c;
    logic                is_m_c, start_c, is_div_c;
    logic                op1_signed_c, op2_signed_c, neg1_c, neg2_c;
    logic                div_zero_c, div_ovf_c, fast_c;
    logic [DATA_W-1:0]   abs1_c, abs2_c, fast_res_c;
    logic [2*DATA_W-1:0] acc_c, prod_fix_c;
    logic [DATA_W-1:0]   quot_fix_c, rem_fix_c, sel_c;
    logic                last_c;
    logic                unused_c;

    // Trace-only and register-index fields are not needed here
    assign unused_c = ^{instaddr_i, inst_i[24:15], inst_i[11:7]};

    // Decode, operand magnitude and fast-path detection for the instruction in ID/EX
    always_comb begin
        funct3_c     = inst_i[14:12];
        is_m_c       = (inst_i[6:0] == INST_TYPE_R_M) && (inst_i[31:25] == FUNCT7_M);
        start_c      = (state_q == MD_IDLE) && is_m_c && !flush_i;
        is_div_c     = funct3_c[2];
        op1_signed_c = (funct3_c == F3_MULH) || (funct3_c == F3_MULHSU) ||
                       (funct3_c == F3_DIV)  || (funct3_c == F3_REM);
        op2_signed_c = (funct3_c == F3_MULH) || (funct3_c == F3_DIV) || (funct3_c == F3_REM);
        neg1_c       = op1_signed_c && op1_i[DATA_W-1];
        neg2_c       = op2_signed_c && op2_i[DATA_W-1];
        abs1_c       = neg1_c ? -op1_i : op1_i;
        abs2_c       = neg2_c ? -op2_i : op2_i;
        div_zero_c   = is_div_c && (op2_i == '0);
        div_ovf_c    = is_div_c && !funct3_c[0] && (op1_i == SMIN) && (op2_i == '1);
        fast_c       = div_zero_c || div_ovf_c;
        if (div_zero_c) begin
            fast_res_c = funct3_c[1] ? op1_i : '1;
        end else begin
            fast_res_c = funct3_c[1] ? '0 : SMIN;
        end
    end

    // Next state and accept-edge latching
    always_comb begin
        state_d    = state_q;
        funct3_d   = funct3_q;
        neg_prod_d = neg_prod_q;
        neg_rem_d  = neg_rem_q;
        fast_d     = fast_q;
        fast_res_d = fast_res_q;
        regs_wen_d = regs_wen_q;
        rd_addr_d  = rd_addr_q;

        case (state_q)
            MD_IDLE: begin
                if (start_c) begin
                    state_d    = fast_c ? MD_DONE : MD_CALC;
                    funct3_d   = funct3_c;
                    neg_prod_d = neg1_c ^ neg2_c;
                    neg_rem_d  = neg1_c;
                    fast_d     = fast_c;
                    fast_res_d = fast_res_c;
                    regs_wen_d = regs_wen_i;
                    rd_addr_d  = rd_addr_i;
                end
            end
            MD_CALC: if (last_c) state_d = MD_DONE;
            MD_DONE: state_d = MD_IDLE;
            default: state_d = MD_IDLE;
        endcase

        if (flush_i) state_d = MD_IDLE;
    end

    // State and latched-operation registers
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= MD_IDLE;
            funct3_q   <= '0;
            neg_prod_q <= 1'b0;
            neg_rem_q  <= 1'b0;
            fast_q     <= 1'b0;
            fast_res_q <= '0;
            regs_wen_q <= 1'b0;
            rd_addr_q  <= '0;
        end else begin
            state_q    <= state_d;
            funct3_q   <= funct3_d;
            neg_prod_q <= neg_prod_d;
            neg_rem_q  <= neg_rem_d;
            fast_q     <= fast_d;
            fast_res_q <= fast_res_d;
            regs_wen_q <= regs_wen_d;
            rd_addr_q  <= rd_addr_d;
        end
    end

    ex_muldiv_md_iter_core #(
        .DATA_W (DATA_W),
        .CNT_W  (CNT_W)
    ) u_core (
        .clk        (clk),
        .rstn       (rstn),
        .load_i     (start_c && !fast_c),
        .is_div_i   (is_div_c),
        .a_i        (abs1_c),
        .b_i        (abs2_c),
        .step_i     (state_q == MD_CALC),
        .acc_o      (acc_c),
        .cnt_last_c (last_c)
    );

    // Sign fix and result select; driven only in DONE
    always_comb begin
        prod_fix_c = neg_prod_q ? -acc_c : acc_c;
        quot_fix_c = neg_prod_q ? -acc_c[DATA_W-1:0] : acc_c[DATA_W-1:0];
        rem_fix_c  = neg_rem_q ? -acc_c[2*DATA_W-1:DATA_W] : acc_c[2*DATA_W-1:DATA_W];
        case (funct3_q)
            F3_MULH, F3_MULHSU, F3_MULHU: sel_c = prod_fix_c[2*DATA_W-1:DATA_W];
            F3_DIV, F3_DIVU:              sel_c = quot_fix_c;
            F3_REM, F3_REMU:              sel_c = rem_fix_c;
            default:                      sel_c = prod_fix_c[DATA_W-1:0];
        endcase
        result_o = (state_q == MD_DONE) ? (fast_q ? fast_res_q : sel_c) : '0;
    end

    // Stall is combinational so ID/EX holds in the accept cycle
    assign stall_req_o    = rstn && (start_c || (state_q == MD_CALC));
    assign busy_o         = (state_q != MD_IDLE);
    assign result_valid_o = (state_q == MD_DONE);
    assign regs_wen_o     = regs_wen_q;
    assign rd_addr_o      = rd_addr_q;

endmodule

// File: tb/tb_ex_muldiv.sv
// Scoreboard bench for ex_muldiv: stimulus pushes expectations, a negedge monitor checks them.
module tb_ex_muldiv;

    localparam logic [2:0] T_MUL = 3'b000, T_MULH = 3'b001, T_MULHSU = 3'b010, T_MULHU = 3'b011;
    localparam logic [2:0] T_DIV = 3'b100, T_DIVU = 3'b101, T_REM = 3'b110, T_REMU = 3'b111;
    localparam logic [31:0] ADD_INST = {7'b0000000, 5'd2, 5'd1, 3'b000, 5'd9, 7'b0110011};

    typedef struct {
        logic [31:0] res;
        logic [4:0]  rd;
        logic        wen;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rstn;
    logic [31:0] inst_i, instaddr_i, op1_i, op2_i;
    logic        regs_wen_i, flush_i;
    logic [4:0]  rd_addr_i;
    logic        stall_req_o, busy_o, result_valid_o, regs_wen_o;
    logic [31:0] result_o;
    logic [4:0]  rd_addr_o;

    exp_t exp_q[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    ex_muldiv dut (
        .clk            (clk),
        .rstn           (rstn),
        .inst_i         (inst_i),
        .instaddr_i     (instaddr_i),
        .op1_i          (op1_i),
        .op2_i          (op2_i),
        .regs_wen_i     (regs_wen_i),
        .rd_addr_i      (rd_addr_i),
        .flush_i        (flush_i),
        .stall_req_o    (stall_req_o),
        .busy_o         (busy_o),
        .result_valid_o (result_valid_o),
        .result_o       (result_o),
        .regs_wen_o     (regs_wen_o),
        .rd_addr_o      (rd_addr_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    function automatic logic [31:0] mk_m(input logic [2:0] f3, input logic [4:0] rd);
        return {7'b0000001, 5'd2, 5'd1, f3, rd, 7'b0110011};
    endfunction

    // Present one M instruction held by stall; returns its accept cycle
    task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input logic [31:0] res, input int lat,
                         output int acc_cyc);
        exp_t e;
        int   n;
        @(posedge clk); #1;
        inst_i     = mk_m(f3, rd);
        op1_i      = a;
        op2_i      = b;
        rd_addr_i  = rd;
        regs_wen_i = (rd != 5'd0);
        acc_cyc    = cyc;
        e.res = res; e.rd = rd; e.wen = (rd != 5'd0); e.cyc = cyc + lat;
        exp_q.push_back(e);
        #1;
        n = 0;
        while (stall_req_o && n < 100) begin
            n++;
            @(posedge clk); #2;
        end
        chk($sformatf("stall_cycles_rd%0d", rd), 64'(n), 64'(lat));
    endtask

    // Monitor: every valid pulse must match the oldest pending expectation
    always @(negedge clk) begin
        if (rstn && result_valid_o) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_valid: got result %08h with nothing pending (cycle %0d)", result_o, cyc);
            end else begin
                mon_e = exp_q.pop_front();
                chk($sformatf("result_rd%0d", mon_e.rd), 64'(result_o), 64'(mon_e.res));
                chk($sformatf("rd_addr_rd%0d", mon_e.rd), 64'(rd_addr_o), 64'(mon_e.rd));
                chk($sformatf("wen_rd%0d", mon_e.rd), 64'(regs_wen_o), 64'(mon_e.wen));
                chk($sformatf("valid_cycle_rd%0d", mon_e.rd), 64'(cyc), 64'(mon_e.cyc));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int a1, a2, dummy;
        rstn = 1'b1; inst_i = '0; instaddr_i = 32'h0000_1000; op1_i = '0; op2_i = '0;
        regs_wen_i = 1'b0; rd_addr_i = '0; flush_i = 1'b0;
        #1 rstn = 1'b0;
        #12;
        chk("rst_stall", 64'(stall_req_o), 0);
        chk("rst_busy", 64'(busy_o), 0);
        chk("rst_valid", 64'(result_valid_o), 0);
        chk("rst_result", 64'(result_o), 0);
        chk("rst_wen", 64'(regs_wen_o), 0);
        chk("rst_rd", 64'(rd_addr_o), 0);
        @(negedge clk); rstn = 1'b1;

        // Multiplies; the first two are back to back
        issue(T_MUL,    32'd7,          32'hFFFF_FFFD, 5'd1, 32'hFFFF_FFEB, 33, a1);
        issue(T_MUL,    32'd12345,      32'd678,       5'd2, 32'h007F_B6F6, 33, a2);
        chk("b2b_accept_spacing", 64'(a2 - a1), 34);
        issue(T_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd3, 32'hFFFF_FFFE, 33, dummy);
        issue(T_MULHSU, 32'hFFFF_FFFF,  32'd2,         5'd4, 32'hFFFF_FFFF, 33, dummy);
        issue(T_MULH,   32'h8000_0000,  32'h8000_0000, 5'd5, 32'h4000_0000, 33, dummy);

        // Fast paths
        issue(T_DIVU,   32'd100,        32'd0,         5'd6, 32'hFFFF_FFFF, 1, dummy);
        issue(T_REMU,   32'd100,        32'd0,         5'd7, 32'd100,       1, dummy);
        issue(T_REM,    32'hFFFF_FFFB,  32'd0,         5'd8, 32'hFFFF_FFFB, 1, dummy);
        issue(T_DIV,    32'h8000_0000,  32'hFFFF_FFFF, 5'd10, 32'h8000_0000, 1, dummy);
        issue(T_REM,    32'h8000_0000,  32'hFFFF_FFFF, 5'd0, 32'h0000_0000, 1, dummy);

        // Iterative divides
        issue(T_DIV,    32'hFFFF_FFF9,  32'd2,         5'd11, 32'hFFFF_FFFD, 33, dummy);
        issue(T_REM,    32'hFFFF_FFF9,  32'd2,         5'd12, 32'hFFFF_FFFF, 33, dummy);
        issue(T_DIV,    32'd7,          32'hFFFF_FFFE, 5'd13, 32'hFFFF_FFFD, 33, dummy);
        issue(T_REM,    32'd7,          32'hFFFF_FFFE, 5'd14, 32'd1,         33, dummy);
        issue(T_REMU,   32'd1000,       32'd7,         5'd15, 32'd6,         33, dummy);

        // Non-M instruction: no stall, no busy
        @(posedge clk); #1;
        inst_i = ADD_INST;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("add_no_stall", 64'(stall_req_o), 0);
            chk("add_no_busy", 64'(busy_o), 0);
            @(posedge clk); #1;
        end

        // Flush in CALC aborts the operation
        inst_i = mk_m(T_MUL, 5'd16); op1_i = 32'd3; op2_i = 32'd5; rd_addr_i = 5'd16; regs_wen_i = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        flush_i = 1'b1;
        #1;
        chk("flush_busy_before", 64'(busy_o), 1);
        @(posedge clk); #1;
        flush_i = 1'b0;
        inst_i  = ADD_INST;
        #1;
        chk("flush_stall_after", 64'(stall_req_o), 0);
        chk("flush_busy_after", 64'(busy_o), 0);
        issue(T_DIVU,   32'd9,          32'd3,         5'd17, 32'd3,         33, dummy);

        // Async reset mid-operation
        @(posedge clk); #1;
        inst_i = mk_m(T_MUL, 5'd18); op1_i = 32'd3; op2_i = 32'd5; rd_addr_i = 5'd18;
        repeat (5) @(posedge clk);
        #3;
        rstn = 1'b0;
        #1;
        chk("arst_stall", 64'(stall_req_o), 0);
        chk("arst_busy", 64'(busy_o), 0);
        chk("arst_rd", 64'(rd_addr_o), 0);
        @(posedge clk); #1;
        inst_i = ADD_INST;
        rstn   = 1'b1;
        issue(T_MUL,    32'd3,          32'd5,         5'd19, 32'd15,        33, dummy);

        @(posedge clk); #1;
        inst_i = ADD_INST;
        repeat (5) @(posedge clk);
        chk("queue_drained", 64'(exp_q.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
